// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
//    Round-robin arbiter that lets CLIENT_CNT requesters share a single memory port.
//    It serves one transaction at a time. It does not preempt the client it is serving.
//    While a request is pending, the next grant goes to the first requester found
//    searching upward from the client after the last one granted.
//
// Ports
//    clk, rst                   clock; asynchronous active-high reset
//    client_requests            per-client request level
//    client_addrs_packed        client i address at [M_WIDTH*i +: M_WIDTH]
//    client_wes                 per-client write enable
//    client_data_widths_packed  client i width code at [2*i +: 2]
//    client_data_outs_packed    client i write data, packed like the addresses
//    mem_data_in, mem_ready     memory read data and completion strobe
//    mem_request                high while a transaction is in flight (ACCESS)
//    mem_addr/data_out/
//    data_width/we_out          fields of the client selected by grant_idx
//    client_readies             one-hot completion, held until the client drops its request
//    client_data_ins_packed     per-client registered read data
//    grant_idx                  current or last granted client
//    busy                       high in any state other than IDLE
//
// state   | meaning
// IDLE    | waiting for a request; the round-robin search runs every cycle
// ACCESS  | memory command is presented for grant_idx; waiting for mem_ready
// RELEASE | ready is held to the client until it drops its request

module mem_rr_arbiter #(
   parameter int         M_WIDTH    = 8,
   parameter int         CLIENT_CNT = 2,
   parameter logic [1:0] MEM_ACC_8  = 2'b00,
   parameter logic [1:0] MEM_ACC_16 = 2'b01,
   parameter logic [1:0] MEM_ACC_32 = 2'b10
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [CLIENT_CNT-1:0]           client_requests,
   input  logic [CLIENT_CNT*M_WIDTH-1:0]   client_addrs_packed,
   input  logic [CLIENT_CNT-1:0]           client_wes,
   input  logic [2*CLIENT_CNT-1:0]         client_data_widths_packed,
   input  logic [CLIENT_CNT*M_WIDTH-1:0]   client_data_outs_packed,
   input  logic [M_WIDTH-1:0]              mem_data_in,
   input  logic                            mem_ready,
   output logic                            mem_request,
   output logic [M_WIDTH-1:0]              mem_addr,
   output logic [M_WIDTH-1:0]              mem_data_out,
   output logic [1:0]                      mem_data_width,
   output logic                            mem_we_out,
   output logic [CLIENT_CNT-1:0]           client_readies,
   output logic [CLIENT_CNT*M_WIDTH-1:0]   client_data_ins_packed,
   output logic [$clog2(CLIENT_CNT)-1:0]   grant_idx,
   output logic                            busy
);

   localparam int GW = $clog2(CLIENT_CNT);

   // The width codes reach memory unchanged. These checks only catch a
   // configuration that would make the codes ambiguous.
   if (CLIENT_CNT < 2 || CLIENT_CNT > 16) begin : g_bad_client_cnt
      $error("mem_rr_arbiter: CLIENT_CNT must be in 2..16");
   end
   if (MEM_ACC_8 == MEM_ACC_16 || MEM_ACC_8 == MEM_ACC_32 || MEM_ACC_16 == MEM_ACC_32) begin : g_bad_acc_codes
      $error("mem_rr_arbiter: MEM_ACC_* width codes must be distinct");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t        state;
   logic [GW-1:0] last_grant;
   logic [GW-1:0] next_grant;
   logic          any_req;
   int            cand;

   // The search walks offsets from CLIENT_CNT down to 1. The last hit is kept,
   // so the result is the nearest requester above last_grant, wrapping past the top.
   always_comb begin
      next_grant = last_grant;
      any_req    = 1'b0;
      cand       = 0;
      for (int k = CLIENT_CNT; k >= 1; k--) begin
         cand = (int'(last_grant) + k) % CLIENT_CNT;
         if (client_requests[cand[GW-1:0]]) begin
            next_grant = cand[GW-1:0];
            any_req    = 1'b1;
         end
      end
   end

   // The memory-side fields always follow the registered grant, even outside ACCESS.
   assign mem_addr       = client_addrs_packed[M_WIDTH*grant_idx +: M_WIDTH];
   assign mem_data_out   = client_data_outs_packed[M_WIDTH*grant_idx +: M_WIDTH];
   assign mem_data_width = client_data_widths_packed[2*grant_idx +: 2];
   assign mem_we_out     = client_wes[grant_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                  <= IDLE;
         grant_idx              <= '0;
         last_grant             <= GW'(CLIENT_CNT - 1);
         mem_request            <= 1'b0;
         busy                   <= 1'b0;
         client_readies         <= '0;
         client_data_ins_packed <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant_idx   <= next_grant;
                  last_grant  <= next_grant;
                  mem_request <= 1'b1;
                  busy        <= 1'b1;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               if (mem_ready) begin
                  if (!client_wes[grant_idx]) begin
                     client_data_ins_packed[M_WIDTH*grant_idx +: M_WIDTH] <= mem_data_in;
                  end
                  client_readies[grant_idx] <= 1'b1;
                  mem_request               <= 1'b0;
                  state                     <= RELEASE;
               end
            end
            RELEASE: begin
               // A client that dropped its request during ACCESS gets a one-cycle pulse.
               if (!client_requests[grant_idx]) begin
                  client_readies <= '0;
                  busy           <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               mem_request <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule
